// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the wide-arithmetic adder controllers built around
// the 32-bit carry_select_adder.
package adder_ctrl_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } adder_state_e;

    // Index counters must stay at least one bit wide even for a single word.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/carry_select_adder.sv
// 32-bit carry-select adder: each 8-bit block precomputes both carry-in
// outcomes and the incoming block carry picks one.
module carry_select_adder
    import adder_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              carry_in,
    output logic [WORD_W-1:0] sum,
    output logic              carry_out
);

    localparam int BLK_W = 8;
    localparam int NBLK  = WORD_W / BLK_W;
    localparam logic [BLK_W:0] ONE = 1;

    logic [NBLK:0] blk_carry;

    assign blk_carry[0] = carry_in;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [BLK_W:0] sum_c0;
        logic [BLK_W:0] sum_c1;

        assign sum_c0 = {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]};
        assign sum_c1 = sum_c0 + ONE;

        assign sum[g*BLK_W +: BLK_W] = blk_carry[g] ? sum_c1[BLK_W-1:0] : sum_c0[BLK_W-1:0];
        assign blk_carry[g+1]        = blk_carry[g] ? sum_c1[BLK_W]     : sum_c0[BLK_W];
    end

    assign carry_out = blk_carry[NBLK];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract engine: one 32-bit word per cycle, LSW first, with a
// registered carry between words and valid/ready handshakes on both sides.
module multiword_add_sequencer
    import adder_ctrl_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORDS*WORD_W-1:0] in_operand_a,
    input  logic [WORDS*WORD_W-1:0] in_operand_b,
    input  logic                    in_carry_in,
    input  logic                    in_subtract,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORDS*WORD_W-1:0] out_sum,
    output logic                    out_carry_out,
    output logic                    busy
);

    localparam int TOTAL_W = WORDS * WORD_W;
    localparam int IDX_W   = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    adder_state_e      state;
    logic [IDX_W-1:0]  word_idx;
    logic              carry_q;
    logic [TOTAL_W-1:0] op_a;
    logic [TOTAL_W-1:0] op_b;

    logic [WORD_W-1:0] adder_a;
    logic [WORD_W-1:0] adder_b;
    logic [WORD_W-1:0] adder_sum;
    logic              adder_co;

    assign in_ready = (state == IDLE);

    // Word select: the counter steers the current slice of each operand.
    assign adder_a = op_a[int'(word_idx)*WORD_W +: WORD_W];
    assign adder_b = op_b[int'(word_idx)*WORD_W +: WORD_W];

    carry_select_adder u_adder (
        .a         (adder_a),
        .b         (adder_b),
        .carry_in  (carry_q),
        .sum       (adder_sum),
        .carry_out (adder_co)
    );

    // NOTE: every register here, operand and result words included, is reset
    // so an aborted operation leaves no stale data behind; use <= throughout
    // so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            word_idx      <= '0;
            carry_q       <= 1'b0;
            op_a          <= '0;
            op_b          <= '0;
            out_sum       <= '0;
            out_carry_out <= 1'b0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= in_operand_a;
                        // Subtraction is A + ~B + 1, so B is stored inverted.
                        op_b     <= in_subtract ? ~in_operand_b : in_operand_b;
                        carry_q  <= in_subtract ? 1'b1 : in_carry_in;
                        word_idx <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    out_sum[int'(word_idx)*WORD_W +: WORD_W] <= adder_sum;
                    carry_q <= adder_co;
                    if (word_idx == LAST_IDX) begin
                        out_carry_out <= adder_co;
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end else begin
                        word_idx <= word_idx + IDX_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer (WORDS=4 and WORDS=1) against
// a plain-arithmetic reference model.
module tb_multiword_add_sequencer;
    import adder_ctrl_pkg::*;

    localparam int W4 = 4;
    localparam int TW = W4 * WORD_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [TW-1:0] in_operand_a = '0;
    logic [TW-1:0] in_operand_b = '0;
    logic          in_carry_in = 1'b0;
    logic          in_subtract = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [TW-1:0] out_sum;
    logic          out_carry_out;
    logic          busy;

    logic              in_valid_1 = 1'b0;
    logic              in_ready_1;
    logic [WORD_W-1:0] in_operand_a_1 = '0;
    logic [WORD_W-1:0] in_operand_b_1 = '0;
    logic              in_carry_in_1 = 1'b0;
    logic              in_subtract_1 = 1'b0;
    logic              out_valid_1;
    logic              out_ready_1 = 1'b0;
    logic [WORD_W-1:0] out_sum_1;
    logic              out_carry_out_1;
    logic              busy_1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multiword_add_sequencer #(.WORDS(W4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_operand_a  (in_operand_a),
        .in_operand_b  (in_operand_b),
        .in_carry_in   (in_carry_in),
        .in_subtract   (in_subtract),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sum       (out_sum),
        .out_carry_out (out_carry_out),
        .busy          (busy)
    );

    multiword_add_sequencer #(.WORDS(1)) dut_1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid_1),
        .in_ready      (in_ready_1),
        .in_operand_a  (in_operand_a_1),
        .in_operand_b  (in_operand_b_1),
        .in_carry_in   (in_carry_in_1),
        .in_subtract   (in_subtract_1),
        .out_valid     (out_valid_1),
        .out_ready     (out_ready_1),
        .out_sum       (out_sum_1),
        .out_carry_out (out_carry_out_1),
        .busy          (busy_1)
    );

    task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {carry, sum}. Subtract reports "no borrow" as carry.
    function automatic logic [TW:0] model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                          input logic cin, input logic sub);
        logic [TW:0] r;
        if (sub) begin
            r[TW-1:0] = a - b;
            r[TW]     = (a >= b);
        end else begin
            r = {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, cin};
        end
        return r;
    endfunction

    function automatic logic [TW-1:0] rand_wide();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic wait_result(input string tag, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        check({tag, "_latency"}, TW'(cycles), TW'(W4));
    endtask

    task automatic run_op(input string tag, input logic [TW-1:0] a, input logic [TW-1:0] b,
                          input logic cin, input logic sub, input logic hold_ready);
        logic [TW:0] exp;
        int          n;
        exp          = model(a, b, cin, sub);
        in_operand_a = a;
        in_operand_b = b;
        in_carry_in  = cin;
        in_subtract  = sub;
        out_ready    = hold_ready;
        in_valid     = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_in_ready_run"}, TW'(in_ready), TW'(0));
        wait_result(tag, n);
        check({tag, "_sum"}, out_sum, exp[TW-1:0]);
        check({tag, "_carry"}, TW'(out_carry_out), TW'(exp[TW]));
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, TW'(out_valid), TW'(0));
        out_ready = 1'b0;
    endtask

    initial begin
        logic [TW-1:0] ones;
        logic [TW-1:0] a1, b1, a2, b2, held_sum;
        logic [TW:0]   exp;
        logic          held_co, cin2, sub2;
        int            cycles;

        ones = '1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", TW'(in_ready), TW'(1));
        check("rst_out_valid", TW'(out_valid), TW'(0));
        check("rst_busy", TW'(busy), TW'(0));
        check("rst_out_sum", out_sum, '0);
        check("rst_carry", TW'(out_carry_out), TW'(0));
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op("ones_plus_one", ones, TW'(1), 1'b0, 1'b0, 1'b0);
        run_op("word_carry", TW'(128'h1_FFFFFFFF), TW'(1), 1'b0, 1'b0, 1'b0);
        run_op("sub_7_5", TW'(7), TW'(5), 1'b1, 1'b1, 1'b0);
        run_op("sub_5_7", TW'(5), TW'(7), 1'b1, 1'b1, 1'b0);
        run_op("ones_ones_cin", ones, ones, 1'b1, 1'b0, 1'b0);
        run_op("ready_early", TW'(128'hFFFFFFFF_00000000_FFFFFFFF), TW'(128'h1_00000001), 1'b0, 1'b0, 1'b1);

        // Single-word instance: one RUN cycle
        in_operand_a_1 = 32'hFFFF_FFFF;
        in_operand_b_1 = 32'hFFFF_FFFF;
        in_carry_in_1  = 1'b1;
        in_valid_1     = 1'b1;
        @(posedge clk); #1;
        in_valid_1 = 1'b0;
        cycles = 0;
        while (!out_valid_1 && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("w1_latency", TW'(cycles), TW'(1));
        check("w1_sum", TW'(out_sum_1), TW'(32'hFFFF_FFFF));
        check("w1_carry", TW'(out_carry_out_1), TW'(1));
        out_ready_1 = 1'b1;
        @(posedge clk); #1;
        check("w1_valid_drop", TW'(out_valid_1), TW'(0));
        out_ready_1 = 1'b0;

        // Randomized operations
        for (int i = 0; i < 12; i++) begin
            run_op("rand", rand_wide(), rand_wide(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Backpressure with a second request held from the start of RUN
        a1 = rand_wide(); b1 = rand_wide();
        a2 = rand_wide(); b2 = rand_wide();
        cin2 = 1'($urandom_range(0, 1));
        sub2 = 1'($urandom_range(0, 1));
        in_operand_a = a1; in_operand_b = b1; in_carry_in = 1'b0; in_subtract = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_operand_a = a2; in_operand_b = b2; in_carry_in = cin2; in_subtract = sub2;
        wait_result("bp_first", cycles);
        exp = model(a1, b1, 1'b0, 1'b0);
        check("bp_first_sum", out_sum, exp[TW-1:0]);
        held_sum = out_sum;
        held_co  = out_carry_out;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid_hold", TW'(out_valid), TW'(1));
            check("bp_sum_hold", out_sum, held_sum);
            check("bp_carry_hold", TW'(out_carry_out), TW'(held_co));
            check("bp_in_ready", TW'(in_ready), TW'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_valid", TW'(out_valid), TW'(0));
        check("bp_release_ready", TW'(in_ready), TW'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_held_busy", TW'(busy), TW'(1));
        wait_result("bp_held", cycles);
        exp = model(a2, b2, cin2, sub2);
        check("bp_held_sum", out_sum, exp[TW-1:0]);
        check("bp_held_carry", TW'(out_carry_out), TW'(exp[TW]));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset while the word index is 2
        in_operand_a = ones; in_operand_b = ones; in_carry_in = 1'b1; in_subtract = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", TW'(out_valid), TW'(0));
        check("midrst_busy", TW'(busy), TW'(0));
        check("midrst_in_ready", TW'(in_ready), TW'(1));
        check("midrst_sum", out_sum, '0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_in_ready", TW'(in_ready), TW'(1));
        run_op("postrst_3_4", TW'(3), TW'(4), 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
